// File: rtl/clock24_pkg.sv
// Shared constants for the 24-hour clock: mode encodings, BCD limits and button bit indices.
package clock24_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10
    } mode_e;

    localparam logic [7:0] BCD_MAX_MS   = 8'h59;
    localparam logic [7:0] BCD_MAX_HOUR = 8'h23;

    localparam int unsigned BTN_MODE   = 0;
    localparam int unsigned BTN_SELECT = 1;
    localparam int unsigned BTN_UP     = 2;

endpackage

// File: rtl/bcd_mod_cnt.sv
// Two-digit BCD modulo counter, wraps MAX -> 00.
// Ports: clk, rst_n (async active-low), inc (advance), clr (force 00, wins over inc),
//        value (registered BCD {tens,units}), carry_c (combinational: inc while at MAX).
module bcd_mod_cnt #(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] value,
    output logic       carry_c
);

    logic [7:0] value_d;

    assign carry_c = inc && (value == MAX);

    // Next value: units 9 rolls into tens, MAX rolls to 00.
    always_comb begin
        value_d = value;
        if (clr) begin
            value_d = 8'h00;
        end else if (inc) begin
            if (value == MAX) begin
                value_d = 8'h00;
            end else if (value[3:0] == 4'h9) begin
                value_d = {value[7:4] + 4'h1, 4'h0};
            end else begin
                value_d = {value[7:4], value[3:0] + 4'h1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 8'h00;
        end else begin
            value <= value_d;
        end
    end

endmodule

// File: rtl/clock24_time_ctrl.sv
// Timekeeping and time-set controller for the 24-hour clock.
// Ports: CLK, RST (async active-low), BTN[2:0] one-cycle pulses {UP,SELECT,MODE};
//        HOUR/MIN/SEC BCD time, MODE (00 run, 01 set hour, 10 set min),
//        BLINK (toggles each half second), SEC_TICK (pulse when seconds advance in RUN).
module clock24_time_ctrl
    import clock24_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 48000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] BTN,
    output logic [7:0] HOUR,
    output logic [7:0] MIN,
    output logic [7:0] SEC,
    output logic [1:0] MODE,
    output logic       BLINK,
    output logic       SEC_TICK
);

    localparam int unsigned CNT_W = $clog2(CLK_FREQ / 2);
    localparam logic [CNT_W-1:0] PRESC_TC = CNT_W'(CLK_FREQ / 2 - 1);

    mode_e            state_q, state_d;
    logic [CNT_W-1:0] presc_q;
    logic             phase_q;
    logic             half_en;
    logic             tick;

    logic sec_inc, sec_clr, min_inc, hour_inc;
    logic sec_carry, min_carry, hour_carry;
    logic presc_clr, sec_tick_d;

    assign half_en = (presc_q == PRESC_TC);
    // Whole-second tick is the second half-second enable, i.e. phase 1 -> 0.
    assign tick    = half_en && phase_q;

    // Mode FSM and counter control; only the highest-priority button acts.
    always_comb begin
        state_d    = state_q;
        sec_inc    = 1'b0;
        sec_clr    = 1'b0;
        min_inc    = 1'b0;
        hour_inc   = 1'b0;
        presc_clr  = 1'b0;
        sec_tick_d = 1'b0;
        case (state_q)
            MODE_RUN: begin
                if (BTN[BTN_MODE]) begin
                    // Transition wins over a coincident tick.
                    state_d = MODE_SET_HOUR;
                    sec_clr = 1'b1;
                end else if (tick) begin
                    sec_inc    = 1'b1;
                    sec_tick_d = 1'b1;
                    min_inc    = sec_carry;
                    hour_inc   = min_carry;
                end
            end
            MODE_SET_HOUR: begin
                if (BTN[BTN_MODE]) begin
                    state_d   = MODE_RUN;
                    presc_clr = 1'b1;
                end else if (BTN[BTN_SELECT]) begin
                    state_d = MODE_SET_MIN;
                end else if (BTN[BTN_UP]) begin
                    hour_inc = 1'b1;
                end
            end
            MODE_SET_MIN: begin
                if (BTN[BTN_MODE]) begin
                    state_d   = MODE_RUN;
                    presc_clr = 1'b1;
                end else if (BTN[BTN_SELECT]) begin
                    state_d = MODE_SET_HOUR;
                end else if (BTN[BTN_UP]) begin
                    // Minute wrap in set mode does not carry into hours.
                    min_inc = 1'b1;
                end
            end
            default: state_d = MODE_RUN;
        endcase
    end

    // State, prescaler, phase and strobe registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= MODE_RUN;
            presc_q  <= '0;
            phase_q  <= 1'b0;
            BLINK    <= 1'b0;
            SEC_TICK <= 1'b0;
        end else begin
            state_q  <= state_d;
            SEC_TICK <= sec_tick_d;
            BLINK    <= BLINK ^ half_en;
            if (presc_clr) begin
                // Restart so the first second after leaving set mode is a full CLK_FREQ cycles.
                presc_q <= '0;
                phase_q <= 1'b0;
            end else if (half_en) begin
                presc_q <= '0;
                phase_q <= ~phase_q;
            end else begin
                presc_q <= presc_q + CNT_W'(1);
            end
        end
    end

    assign MODE = state_q;

    bcd_mod_cnt #(.MAX(BCD_MAX_MS)) u_sec (
        .clk     (CLK),
        .rst_n   (RST),
        .inc     (sec_inc),
        .clr     (sec_clr),
        .value   (SEC),
        .carry_c (sec_carry)
    );

    bcd_mod_cnt #(.MAX(BCD_MAX_MS)) u_min (
        .clk     (CLK),
        .rst_n   (RST),
        .inc     (min_inc),
        .clr     (1'b0),
        .value   (MIN),
        .carry_c (min_carry)
    );

    bcd_mod_cnt #(.MAX(BCD_MAX_HOUR)) u_hour (
        .clk     (CLK),
        .rst_n   (RST),
        .inc     (hour_inc),
        .clr     (1'b0),
        .value   (HOUR),
        .carry_c (hour_carry)
    );

    logic unused_c;
    assign unused_c = hour_carry;

endmodule
